// File: rtl/cdf_pipeline.sv
// cdf_pipeline: streams histogram bins from m2, writes the running
// cumulative sum to m3, and reports the first nonzero CDF and the total.
module cdf_pipeline #(
  parameter int          NUM_BINS = 256,
  parameter logic [15:0] TAG      = 16'hAAAA
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] m2ReadVal,
  output logic [15:0]  m2ReadAddr,
  output logic [15:0]  m3WriteAddr,
  output logic [127:0] m3WriteVal,
  output logic         m3WE,
  output logic [23:0]  cdfMin,
  output logic [23:0]  totalCount,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic [15:0] PEN = 16'(NUM_BINS - 2);

  state_t      state;
  logic        req_v;
  logic        dat_v;
  logic [15:0] wr_idx;
  logic [23:0] sum;
  logic [15:0] cnt;
  logic [24:0] sum_ext;
  logic [23:0] nsum;
  logic        unused_hi;

  assign unused_hi = ^m2ReadVal[127:32];

  // untagged words are unwritten bins; running sum saturates
  always_comb begin
    cnt = 16'h0;
    if (m2ReadVal[31:16] == TAG)
      cnt = m2ReadVal[15:0];
    sum_ext = {1'b0, sum} + {9'h0, cnt};
    nsum = sum_ext[24] ? 24'hFFFFFF : sum_ext[23:0];
  end

  // sequencer: address issue, 2-cycle read pipe, CDF write-back
  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      req_v       <= 1'b0;
      dat_v       <= 1'b0;
      wr_idx      <= 16'h0;
      sum         <= 24'h0;
      m2ReadAddr  <= 16'h0;
      m3WriteAddr <= 16'h0;
      m3WriteVal  <= 128'h0;
      m3WE        <= 1'b0;
      cdfMin      <= 24'h0;
      totalCount  <= 24'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      m3WE  <= 1'b0;
      dat_v <= req_v;
      if (dat_v) begin
        sum         <= nsum;
        m3WE        <= 1'b1;
        m3WriteAddr <= wr_idx;
        m3WriteVal  <= {88'h0, TAG, nsum};
        wr_idx      <= wr_idx + 16'd1;
        if (cdfMin == 24'h0 && nsum != 24'h0)
          cdfMin <= nsum;
      end
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= (NUM_BINS == 1) ? DRAIN : READ;
            m2ReadAddr <= 16'h0;
            busy       <= 1'b1;
            done       <= 1'b0;
            sum        <= 24'h0;
            cdfMin     <= 24'h0;
            totalCount <= 24'h0;
            req_v      <= 1'b1;
            wr_idx     <= 16'h0;
          end
        end
        READ: begin
          m2ReadAddr <= m2ReadAddr + 16'd1;
          if (m2ReadAddr == PEN)
            state <= DRAIN;
        end
        DRAIN: begin
          req_v <= 1'b0;
          if (!req_v && !dat_v) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            totalCount <= sum;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdf_pipeline.sv
// tb_cdf_pipeline: directed passes over a modelled m2 scratchpad with a
// write scoreboard for m3.
module tb_cdf_pipeline;

  localparam logic [15:0] TAG = 16'hAAAA;

  typedef struct {
    logic [15:0]  a;
    logic [127:0] v;
  } wr_t;

  logic         clock = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] m2ReadVal;
  logic [15:0]  m2ReadAddr;
  logic [15:0]  m3WriteAddr;
  logic [127:0] m3WriteVal;
  logic         m3WE;
  logic [23:0]  cdfMin;
  logic [23:0]  totalCount;
  logic         busy;
  logic         done;

  logic [127:0] mem [256];
  wr_t          q [$];
  int           total = 0;
  int           bad = 0;
  int           nw = 0;
  logic [23:0]  emin;
  logic [23:0]  etot;

  cdf_pipeline dut (
    .clock      (clock),
    .rst        (rst),
    .start      (start),
    .m2ReadVal  (m2ReadVal),
    .m2ReadAddr (m2ReadAddr),
    .m3WriteAddr(m3WriteAddr),
    .m3WriteVal (m3WriteVal),
    .m3WE       (m3WE),
    .cdfMin     (cdfMin),
    .totalCount (totalCount),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    m2ReadVal <= mem[m2ReadAddr[7:0]];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (m3WE === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_write", {112'h0, m3WriteAddr}, 128'h0);
      end else begin
        wr_t e;
        e = q.pop_front();
        nw++;
        chk("wr_addr", {112'h0, m3WriteAddr}, {112'h0, e.a});
        chk("wr_val", m3WriteVal, e.v);
      end
    end
  end

  task automatic model();
    logic [24:0] s;
    logic [15:0] c;
    wr_t w;
    q.delete();
    nw = 0;
    s = 25'h0;
    emin = 24'h0;
    for (int k = 0; k < 256; k++) begin
      c = (mem[k][31:16] == TAG) ? mem[k][15:0] : 16'h0;
      s = s + {9'h0, c};
      if (s > 25'hFFFFFF) s = 25'hFFFFFF;
      if (emin == 24'h0) emin = s[23:0];
      w.a = 16'(k);
      w.v = {88'h0, TAG, s[23:0]};
      q.push_back(w);
    end
    etot = s[23:0];
  endtask

  task automatic wait_done(input int n0, input bit hold, output int n);
    n = n0;
    while (n < 400) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (n == 1 && !hold) start = 1'b0;
      if (n <= 2) chk("we_early", {127'h0, m3WE}, 128'h0);
      if (done === 1'b1) break;
    end
  endtask

  task automatic check_end(input int n);
    chk("latency", 128'(n), 128'd259);
    chk("done", {127'h0, done}, 128'h1);
    chk("busy_end", {127'h0, busy}, 128'h0);
    chk("cdfMin", {104'h0, cdfMin}, {104'h0, emin});
    chk("totalCount", {104'h0, totalCount}, {104'h0, etot});
    chk("writes", 128'(nw), 128'd256);
    chk("q_empty", 128'(q.size()), 128'h0);
    chk("rd_hold", {112'h0, m2ReadAddr}, 128'd255);
  endtask

  task automatic run_pass();
    int n;
    model();
    @(negedge clock);
    start = 1'b1;
    wait_done(0, 1'b0, n);
    check_end(n);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ra"}, {112'h0, m2ReadAddr}, 128'h0);
    chk({tag, "_wa"}, {112'h0, m3WriteAddr}, 128'h0);
    chk({tag, "_wv"}, m3WriteVal, 128'h0);
    chk({tag, "_we"}, {127'h0, m3WE}, 128'h0);
    chk({tag, "_min"}, {104'h0, cdfMin}, 128'h0);
    chk({tag, "_tot"}, {104'h0, totalCount}, 128'h0);
    chk({tag, "_busy"}, {127'h0, busy}, 128'h0);
    chk({tag, "_done"}, {127'h0, done}, 128'h0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = 128'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_zero("reset");

    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("rst_prio_busy", {127'h0, busy}, 128'h0);
    rst = 1'b0;
    start = 1'b0;

    for (int k = 0; k < 256; k++)
      mem[k] = {96'h0, 16'h0, 16'($urandom)};
    run_pass();

    for (int k = 0; k < 256; k++) mem[k] = 128'h0;
    mem[3] = {96'h0, TAG, 16'd5};
    mem[4] = {96'h0, TAG, 16'd2};
    mem[10] = {96'h0, 16'h1234, 16'd100};
    mem[255] = {96'h0, TAG, 16'd9};
    run_pass();
    chk("sparse_min", {104'h0, cdfMin}, 128'd5);
    chk("sparse_tot", {104'h0, totalCount}, 128'd16);

    for (int k = 0; k < 256; k++) mem[k] = {96'h0, TAG, 16'hFFFF};
    run_pass();

    for (int k = 0; k < 256; k++)
      mem[k] = {32'($urandom), 32'($urandom), 32'($urandom),
                ($urandom_range(0, 1) == 1) ? TAG : 16'h5555,
                16'($urandom)};
    run_pass();

    model();
    @(negedge clock);
    start = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (i == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk_zero("midrst");
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 9; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("post_rst_we", {127'h0, m3WE}, 128'h0);
    end
    run_pass();

    model();
    @(negedge clock);
    start = 1'b1;
    wait_done(0, 1'b1, n);
    check_end(n);
    model();
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    chk("held_done_1cyc", {127'h0, done}, 128'h0);
    chk("held_restart", {127'h0, busy}, 128'h1);
    wait_done(1, 1'b1, n);
    check_end(n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
